// File: rtl/id_queue_rw_if.sv
// id_queue_rw_if: bundle of push, lookup/pop, count-query and status signals
// for the ID-ordered queue.
//   push side   : inp_id_i, inp_data_i, inp_valid_i -> inp_ready_o
//   lookup side : oup_id_i, oup_req_i, oup_pop_i -> oup_data_o,
//                 oup_data_valid_o, oup_gnt_o
//   count query : cnt_id_i -> cnt_o
//   status      : usage_o, empty_o, full_o
// The slave modport is used by the queue; the master modport by its user.
interface id_queue_rw_if #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 4
);
  logic [ID_WIDTH-1:0]   inp_id_i;
  logic [DATA_WIDTH-1:0] inp_data_i;
  logic                  inp_valid_i;
  logic                  inp_ready_o;
  logic [ID_WIDTH-1:0]   oup_id_i;
  logic                  oup_req_i;
  logic                  oup_pop_i;
  logic [DATA_WIDTH-1:0] oup_data_o;
  logic                  oup_data_valid_o;
  logic                  oup_gnt_o;
  logic [ID_WIDTH-1:0]   cnt_id_i;
  logic [CNT_WIDTH-1:0]  cnt_o;
  logic [CNT_WIDTH-1:0]  usage_o;
  logic                  empty_o;
  logic                  full_o;

  modport slave (
    input  inp_id_i, inp_data_i, inp_valid_i, oup_id_i, oup_req_i, oup_pop_i, cnt_id_i,
    output inp_ready_o, oup_data_o, oup_data_valid_o, oup_gnt_o, cnt_o, usage_o, empty_o, full_o
  );

  modport master (
    output inp_id_i, inp_data_i, inp_valid_i, oup_id_i, oup_req_i, oup_pop_i, cnt_id_i,
    input  inp_ready_o, oup_data_o, oup_data_valid_o, oup_gnt_o, cnt_o, usage_o, empty_o, full_o
  );
endinterface

// File: rtl/id_queue_rw.sv
// id_queue_rw: ID-ordered queue with one push and one lookup/pop per cycle.
// Elements sharing an ID leave in FIFO order; different IDs are independent.
// Storage is a head/tail table (one entry per live ID) plus a linked data
// table. Lookups are combinational; all updates land on the next clock edge.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, empties the queue
//   flush_i : synchronous flush, empties the queue, overrides push/pop
//   bus     : id_queue_rw_if.slave (push, lookup/pop, count query, status)
module id_queue_rw #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned CAPACITY   = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_PER_ID = CAPACITY,
  parameter int unsigned CNT_WIDTH  = $clog2(CAPACITY + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  id_queue_rw_if.slave bus
);
  localparam int unsigned HT     = ((1 << ID_WIDTH) < CAPACITY) ? (1 << ID_WIDTH) : CAPACITY;
  localparam int unsigned DIDX_W = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
  localparam int unsigned HIDX_W = (HT > 1) ? $clog2(HT) : 1;

  typedef struct packed {
    logic                  used;
    logic [ID_WIDTH-1:0]   id;
    logic [DIDX_W-1:0]     head;
    logic [DIDX_W-1:0]     tail;
    logic [CNT_WIDTH-1:0]  count;
  } ht_t;

  typedef struct packed {
    logic                  used;
    logic [DIDX_W-1:0]     next;
    logic [DATA_WIDTH-1:0] data;
  } dt_t;

  ht_t                  ht_q [HT];
  ht_t                  ht_d [HT];
  dt_t                  dt_q [CAPACITY];
  dt_t                  dt_d [CAPACITY];
  logic [CNT_WIDTH-1:0] usage_q, usage_d;

  logic [HT-1:0]       oup_match, inp_match, cnt_match, ht_free;
  logic [CAPACITY-1:0] dt_free;

  for (genvar gi = 0; gi < HT; gi++) begin : g_ht
    assign oup_match[gi] = ht_q[gi].used && (ht_q[gi].id == bus.oup_id_i);
    assign inp_match[gi] = ht_q[gi].used && (ht_q[gi].id == bus.inp_id_i);
    assign cnt_match[gi] = ht_q[gi].used && (ht_q[gi].id == bus.cnt_id_i);
    assign ht_free[gi]   = !ht_q[gi].used;
  end

  for (genvar gi = 0; gi < CAPACITY; gi++) begin : g_dt
    assign dt_free[gi] = !dt_q[gi].used;
  end

  logic                 oup_hit, inp_hit;
  logic [HIDX_W-1:0]    oup_idx, inp_idx, free_ht_idx;
  logic [DIDX_W-1:0]    free_dt_idx;
  logic [CNT_WIDTH-1:0] inp_cnt, cnt_val;

  // An ID owns at most one table entry, so the match encoders never see
  // more than one bit set; the descending loops leave the lowest free index.
  always_comb begin
    oup_idx     = '0;
    inp_idx     = '0;
    free_ht_idx = '0;
    free_dt_idx = '0;
    cnt_val     = '0;
    for (int i = HT - 1; i >= 0; i--) begin
      if (oup_match[i]) oup_idx = HIDX_W'(i);
      if (inp_match[i]) inp_idx = HIDX_W'(i);
      if (ht_free[i])   free_ht_idx = HIDX_W'(i);
      if (cnt_match[i]) cnt_val = ht_q[i].count;
    end
    for (int i = CAPACITY - 1; i >= 0; i--) begin
      if (dt_free[i]) free_dt_idx = DIDX_W'(i);
    end
    oup_hit = |oup_match;
    inp_hit = |inp_match;
    inp_cnt = inp_hit ? ht_q[inp_idx].count : '0;
  end

  logic full, empty, inp_ready, gnt, do_push, do_pop, same_id;
  logic [DIDX_W-1:0] pop_head;

  assign full      = (usage_q == CNT_WIDTH'(CAPACITY));
  assign empty     = (usage_q == '0);
  // Ready depends only on pre-edge state: a slot freed by a same-cycle pop
  // is not offered to the push until the following cycle.
  assign inp_ready = !rst_i && !flush_i && !full && (inp_cnt < CNT_WIDTH'(MAX_PER_ID));
  assign gnt       = bus.oup_req_i && !rst_i && !flush_i;
  assign do_push   = bus.inp_valid_i && inp_ready;
  assign do_pop    = gnt && bus.oup_pop_i && oup_hit;
  assign same_id   = do_pop && inp_hit && (inp_idx == oup_idx);
  assign pop_head  = ht_q[oup_idx].head;

  assign bus.inp_ready_o      = inp_ready;
  assign bus.oup_gnt_o        = gnt;
  assign bus.oup_data_valid_o = oup_hit && !rst_i;
  assign bus.oup_data_o       = dt_q[pop_head].data;
  assign bus.cnt_o            = cnt_val;
  assign bus.usage_o          = usage_q;
  assign bus.empty_o          = empty;
  assign bus.full_o           = full;

  always_comb begin
    ht_d    = ht_q;
    dt_d    = dt_q;
    usage_d = usage_q + CNT_WIDTH'(do_push) - CNT_WIDTH'(do_pop);

    if (do_pop) begin
      dt_d[pop_head].used = 1'b0;
      if (ht_q[oup_idx].count == CNT_WIDTH'(1)) begin
        ht_d[oup_idx].used = 1'b0;
      end else begin
        ht_d[oup_idx].head  = dt_q[pop_head].next;
        ht_d[oup_idx].count = ht_q[oup_idx].count - CNT_WIDTH'(1);
      end
    end

    if (do_push) begin
      dt_d[free_dt_idx].used = 1'b1;
      dt_d[free_dt_idx].next = '0;
      dt_d[free_dt_idx].data = bus.inp_data_i;
      if (!inp_hit) begin
        ht_d[free_ht_idx].used  = 1'b1;
        ht_d[free_ht_idx].id    = bus.inp_id_i;
        ht_d[free_ht_idx].head  = free_dt_idx;
        ht_d[free_ht_idx].tail  = free_dt_idx;
        ht_d[free_ht_idx].count = CNT_WIDTH'(1);
      end else if (same_id && (ht_q[inp_idx].count == CNT_WIDTH'(1))) begin
        // The only element leaves as the new one arrives: keep the entry
        // alive and point it at the new slot instead of freeing it.
        ht_d[inp_idx].used  = 1'b1;
        ht_d[inp_idx].head  = free_dt_idx;
        ht_d[inp_idx].tail  = free_dt_idx;
        ht_d[inp_idx].count = CNT_WIDTH'(1);
      end else begin
        // Count builds on ht_d so a same-ID pop's decrement is cancelled.
        dt_d[ht_q[inp_idx].tail].next = free_dt_idx;
        ht_d[inp_idx].tail            = free_dt_idx;
        ht_d[inp_idx].count           = ht_d[inp_idx].count + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int i = 0; i < HT; i++)       ht_q[i] <= '0;
      for (int i = 0; i < CAPACITY; i++) dt_q[i] <= '0;
      usage_q <= '0;
    end else begin
      ht_q    <= ht_d;
      dt_q    <= dt_d;
      usage_q <= usage_d;
    end
  end

  // Consistency checks between the two tables and the occupancy counter.
  int unsigned sum_cnt, free_cnt;
  always_comb begin
    sum_cnt  = 0;
    free_cnt = 0;
    for (int i = 0; i < HT; i++)
      if (ht_q[i].used) sum_cnt = sum_cnt + 32'(ht_q[i].count);
    for (int i = 0; i < CAPACITY; i++)
      if (!dt_q[i].used) free_cnt = free_cnt + 1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(bus.inp_valid_i && do_push && !inp_ready));
      assert (!do_push || (|dt_free));
      assert (!(do_push && !inp_hit) || (|ht_free));
      assert (sum_cnt == 32'(usage_q));
      assert (free_cnt == CAPACITY - 32'(usage_q));
    end
  end
endmodule

// File: tb/tb_id_queue_rw.sv
module tb_id_queue_rw;
  localparam int CAP  = 8;
  localparam int MAXP = 2;

  typedef struct {
    int          id;
    logic [31:0] data;
  } elem_t;

  logic clk = 1'b0;
  logic rst, flush;
  always #5 clk = ~clk;

  id_queue_rw_if #(.ID_WIDTH(4), .DATA_WIDTH(32), .CNT_WIDTH(4)) bus ();

  id_queue_rw #(
    .ID_WIDTH(4), .CAPACITY(CAP), .DATA_WIDTH(32), .MAX_PER_ID(MAXP)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  // Reference: every stored element in arrival order. Per-ID FIFO order is
  // the order of first appearance of that ID in this list.
  elem_t mq[$];
  bit    known = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc   = 0;

  logic [31:0] obs_data;
  logic        obs_valid, obs_ready, obs_gnt, obs_empty, obs_full;
  logic [3:0]  obs_cnt, obs_usage;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input bit f, input bit iv, input int iid,
                      input logic [31:0] idat, input bit rq, input bit pp,
                      input int oid, input int cid);
    int    total, cin, ccnt, hidx;
    bit    exp_ready, exp_gnt, exp_hit, do_push, do_pop;
    elem_t e;
    rst             = r;
    flush           = f;
    bus.inp_valid_i = iv;
    bus.inp_id_i    = 4'(iid);
    bus.inp_data_i  = idat;
    bus.oup_req_i   = rq;
    bus.oup_pop_i   = pp;
    bus.oup_id_i    = 4'(oid);
    bus.cnt_id_i    = 4'(cid);
    @(negedge clk);
    total = mq.size();
    cin   = 0;
    ccnt  = 0;
    hidx  = -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].id == iid) cin++;
      if (mq[i].id == cid) ccnt++;
      if (mq[i].id == oid && hidx < 0) hidx = i;
    end
    exp_ready = !r && !f && known && (total < CAP) && (cin < MAXP);
    exp_gnt   = rq && !r && !f;
    exp_hit   = known && !r && (hidx >= 0);
    obs_data  = bus.oup_data_o;
    obs_valid = bus.oup_data_valid_o;
    obs_ready = bus.inp_ready_o;
    obs_gnt   = bus.oup_gnt_o;
    obs_cnt   = bus.cnt_o;
    obs_usage = bus.usage_o;
    obs_empty = bus.empty_o;
    obs_full  = bus.full_o;
    check("inp_ready", 64'(obs_ready), 64'(exp_ready));
    check("oup_gnt", 64'(obs_gnt), 64'(exp_gnt));
    if (known || r) check("data_valid", 64'(obs_valid), 64'(exp_hit));
    if (known) begin
      check("usage", 64'(obs_usage), 64'(total));
      check("empty", 64'(obs_empty), 64'(total == 0));
      check("full", 64'(obs_full), 64'(total == CAP));
      check("cnt", 64'(obs_cnt), 64'(ccnt));
      if (exp_hit) check("oup_data", 64'(obs_data), 64'(mq[hidx].data));
    end
    do_push = iv && exp_ready;
    do_pop  = exp_gnt && pp && exp_hit;
    @(posedge clk);
    #1;
    if (r || f) begin
      mq.delete();
      known = 1;
    end else begin
      if (do_pop) mq.delete(hidx);
      if (do_push) begin
        e.id   = iid;
        e.data = idat;
        mq.push_back(e);
      end
    end
    if (r || f || do_push || do_pop)
      $display("cyc %0d rst=%0d flush=%0d push=%0d(id %0d) pop=%0d(id %0d) usage=%0d",
               cyc, r, f, do_push, iid, do_pop, oid, mq.size());
    cyc++;
  endtask

  task automatic push1(input int id, input logic [31:0] d);
    step(0, 0, 1, id, d, 0, 0, 0, id);
  endtask

  task automatic look(input int id, input bit p);
    step(0, 0, 0, 0, 32'h0, 1, p, id, id);
  endtask

  task automatic do_flush();
    step(0, 1, 0, 0, 32'h0, 0, 0, 0, 0);
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    step(1, 0, 1, 3, 32'h1, 1, 1, 3, 3);
    step(1, 0, 1, 3, 32'h1, 1, 1, 3, 3);
    step(0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    check("rst_usage", 64'(obs_usage), 64'd0);
    check("rst_empty", 64'(obs_empty), 64'd1);
    check("rst_full", 64'(obs_full), 64'd0);

    // 1: two elements on id 3, one on id 5
    push1(3, 32'hA);
    push1(3, 32'hB);
    push1(5, 32'hC);
    look(3, 0);
    check("t1_data", 64'(obs_data), 64'hA);
    check("t1_valid", 64'(obs_valid), 64'd1);
    check("t1_usage", 64'(obs_usage), 64'd3);
    check("t1_cnt3", 64'(obs_cnt), 64'd2);

    // 2: pop id 5 then look again
    look(5, 1);
    check("t2_data", 64'(obs_data), 64'hC);
    check("t2_valid", 64'(obs_valid), 64'd1);
    look(5, 0);
    check("t2_miss", 64'(obs_valid), 64'd0);
    check("t2_cnt5", 64'(obs_cnt), 64'd0);
    check("t2_usage", 64'(obs_usage), 64'd2);

    // 3: per-ID limit of two
    do_flush();
    push1(1, 32'h11);
    push1(1, 32'h12);
    push1(1, 32'h13);
    check("t3_ready", 64'(obs_ready), 64'd0);
    look(1, 0);
    check("t3_cnt1", 64'(obs_cnt), 64'd2);
    check("t3_usage", 64'(obs_usage), 64'd2);

    // 4: full, push and pop different IDs together
    do_flush();
    for (int i = 0; i < CAP; i++) push1(i, 32'h40 + 32'(i));
    step(0, 0, 1, 8, 32'h48, 1, 1, 0, 0);
    check("t4_full", 64'(obs_full), 64'd1);
    check("t4_ready", 64'(obs_ready), 64'd0);
    check("t4_pop", 64'(obs_data), 64'h40);
    step(0, 0, 0, 9, 32'h0, 0, 0, 0, 0);
    check("t4_ready_next", 64'(obs_ready), 64'd1);
    check("t4_usage", 64'(obs_usage), 64'd7);

    // 5: same ID, single element, push and pop together
    do_flush();
    push1(2, 32'h5A);
    step(0, 0, 1, 2, 32'h5B, 1, 1, 2, 2);
    check("t5_pop", 64'(obs_data), 64'h5A);
    look(2, 0);
    check("t5_data", 64'(obs_data), 64'h5B);
    check("t5_cnt2", 64'(obs_cnt), 64'd1);
    check("t5_usage", 64'(obs_usage), 64'd1);

    // 6: flush with a concurrent push
    do_flush();
    for (int i = 0; i < 5; i++) push1(i, 32'h60 + 32'(i));
    step(0, 1, 1, 7, 32'h67, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      look(i, 0);
      check("t6_miss", 64'(obs_valid), 64'd0);
      check("t6_usage", 64'(obs_usage), 64'd0);
      check("t6_empty", 64'(obs_empty), 64'd1);
    end

    // Random traffic against the reference list
    for (int n = 0; n < 800; n++) begin
      bit r, f, iv, rq, pp;
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 59) == 0);
      iv = ($urandom_range(0, 9) < 6);
      rq = ($urandom_range(0, 9) < 7);
      pp = ($urandom_range(0, 9) < 5);
      step(r, f, iv, int'($urandom_range(0, 9)), $urandom, rq, pp,
           int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/id_queue_rw.md
Name: id_queue_rw

Overview:
- ID-ordered queue. Among all elements with the same ID, order is FIFO; elements with different IDs can be dequeued in any order.
- Unlike the single-port ID queue, it accepts one push and one pop in the same cycle.
- It also enforces a per-ID occupancy limit, and exposes per-ID counts, global occupancy and a synchronous flush.
- Sits between a transaction issuer and out-of-order responders, e.g. AXI ID remapping and reorder buffers.

Parameters:
- ID_WIDTH, 4, width of element ID (>=1).
- CAPACITY, 8, total element storage (>=1).
- DATA_WIDTH, 32, payload width (>=1).
- MAX_PER_ID, CAPACITY, maximum elements held per ID (1..CAPACITY).
- CNT_WIDTH, $clog2(CAPACITY+1), derived, DO NOT OVERRIDE.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  drop all contents
- inp_id_i  in  ID_WIDTH  push ID
- inp_data_i  in  DATA_WIDTH  push payload
- inp_valid_i  in  1  push request
- inp_ready_o  out  1  push accepted when valid&&ready
- oup_id_i  in  ID_WIDTH  lookup ID
- oup_req_i  in  1  lookup request
- oup_pop_i  in  1  dequeue on lookup hit
- oup_data_o  out  DATA_WIDTH  head payload of oup_id_i
- oup_data_valid_o  out  1  lookup hit
- oup_gnt_o  out  1  lookup granted
- cnt_id_i  in  ID_WIDTH  count-query ID
- cnt_o  out  CNT_WIDTH  elements stored for cnt_id_i
- usage_o  out  CNT_WIDTH  total elements stored
- empty_o  out  1  usage_o==0
- full_o  out  1  usage_o==CAPACITY

Behaviour:
- Storage: head/tail table with HT=min(2**ID_WIDTH, CAPACITY) entries, each holding {id, head, tail, count, free}. Linked data table of CAPACITY entries, each holding {data, next, free}. Free slots are chosen lowest-index-first.
- Reset (rst_i=1 at posedge): all entries free; usage_o=0, empty_o=1, full_o=0. While rst_i is asserted, inp_ready_o=0, oup_gnt_o=0 and oup_data_valid_o=0. Reset asserted mid-operation discards all contents at that edge.
- flush_i: same effect as reset at the next edge and overrides a push/pop in that cycle. Outputs in the flush cycle are computed from current state. During flush inp_ready_o=0 and oup_gnt_o=0.
- Push:
  - inp_ready_o = !full_o && cnt(inp_id_i) < MAX_PER_ID.
  - Combinational from state and inp_id_i; independent of inp_valid_i and of any same-cycle pop (no pass-through).
  - Accepted element is written at the next edge.
  - New ID: allocate a head/tail entry with count=1.
  - Existing ID: link after the tail, tail=new slot, count+1.
- Lookup/pop:
  - oup_gnt_o = oup_req_i whenever not in reset/flush (always granted).
  - oup_data_valid_o=1 and oup_data_o=head payload iff the ID is present. Both are combinational, zero latency.
  - On a miss, oup_data_o is don't-care.
  - Pop when oup_req_i && oup_pop_i && hit. If count==1, free the head/tail entry; otherwise head=head.next, count-1. The head data slot is freed.
- Simultaneous push and pop, evaluated on pre-edge state:
  - Different IDs: both take effect.
  - Same ID, count>=2: pop advances head, push appends tail; count unchanged.
  - Same ID, count==1: popped slot freed; the pushed element becomes the sole entry (head=tail=new slot, count=1). The head/tail entry is reused, not freed and reallocated.
  - Same ID, count==0: lookup misses and the push creates the entry. The pushed element is not visible to the lookup in the same cycle.
  - Full and pop in the same cycle: inp_ready_o stays 0 that cycle; the freed slot is usable next cycle.
  - The new slot never equals the slot being popped (the free slot is chosen pre-edge).
- Counters:
  - usage_o next = usage + push - pop (net 0 when both occur).
  - cnt_o is combinational and returns 0 for absent IDs.
  - All counters saturate by construction; never wrap.
- Assertions (simulation only):
  - Push accepted with ready=0 is impossible by design.
  - Sum of per-ID counts == usage_o.
  - Number of free data slots == CAPACITY-usage_o.

Test Plan:
1. Reset, then push (id=3, A), (id=3, B), (id=5, C). Then lookup id=3 without pop -> data=A, valid=1; usage_o=3, cnt(3)=2.
2. Pop id=5, then lookup id=5 -> first returns C valid=1; next cycle valid=0, cnt(5)=0, usage_o=2.
3. MAX_PER_ID=2, push id=1 three times back-to-back -> third cycle inp_ready_o=0, cnt(1)=2, usage_o unchanged.
4. CAPACITY=8, fill to full, then push and pop different IDs in the same cycle -> ready=0 that cycle; pop succeeds; next cycle ready=1, usage_o=7.
5. id=2 holds {X}; push (2, Y) and pop 2 in the same cycle -> returns X; next cycle lookup 2 returns Y, cnt(2)=1, usage_o unchanged.
6. Five elements stored, assert flush_i with concurrent push -> next cycle usage_o=0, empty_o=1, all lookups miss, push discarded.
